vedic_mac_accumulator: RTL

//  Dot-product back end for the 32x32 Vedic multiplier: accepts operand pairs with valid/last,

---
 rtl/vedic_mac_accumulator_pkg.sv | 19 +
 rtl/vedic_valid_delay.sv | 37 +++
 rtl/vedic_mac_accumulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/vedic_mac_accumulator_pkg.sv
// Shared definitions for the Vedic multiplier dot-product back end:
// default widths, pipeline depth, accumulator sizing and FSM state encoding.
package vedic_mac_accumulator_pkg;

  localparam int DEF_N       = 32;
  localparam int DEF_GUARD   = 8;
  localparam int DEF_MUL_LAT = 2;
  localparam int DEF_CNT_W   = 16;

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Accumulator holds a full product plus guard bits for long vectors.
  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

endpackage

// File: rtl/vedic_valid_delay.sv
// Tracks {valid,last} of accepted operand pairs alongside a fixed-latency
// multiplier so each product can be matched with its pair's flags.
module vedic_valid_delay
  import vedic_mac_accumulator_pkg::*;
#(
  parameter int DEPTH = DEF_MUL_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_last,
  output logic tail_valid,
  output logic tail_last
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] lst;

  // last is gated by valid so a bubble never carries a stray last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
    end else begin
      vld[0] <= in_valid;
      lst[0] <= in_valid && in_last;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  assign tail_valid = vld[DEPTH-1];
  assign tail_last  = lst[DEPTH-1];

endmodule

// File: rtl/vedic_mac_accumulator.sv
// Dot-product accumulator fed by an external pipelined 32x32 Vedic multiplier:
// accepts operand pairs, accumulates aligned products, emits one sum per vector.
module vedic_mac_accumulator
  import vedic_mac_accumulator_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int GUARD   = DEF_GUARD,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int ACC_W   = acc_width(N, GUARD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             op_last,
  input  logic [N-1:0]     op_a,
  input  logic [N-1:0]     op_b,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [2*N-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             fire;
  logic             tail_valid;
  logic             tail_last;
  logic [ACC_W:0]   sum;
  logic             carry;

  assign mul_a    = op_a;
  assign mul_b    = op_b;
  assign op_ready = (state == ST_ACCUM);
  assign fire     = op_valid && op_ready;

  vedic_valid_delay #(
    .DEPTH (MUL_LAT)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (fire),
    .in_last    (op_last),
    .tail_valid (tail_valid),
    .tail_last  (tail_last)
  );

  // One extra bit catches the wrap; the stored sum is taken modulo 2^ACC_W.
  assign sum   = {1'b0, acc} + {{(ACC_W + 1 - 2 * N){1'b0}}, mul_p};
  assign carry = sum[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (fire && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
      case (state)
        ST_ACCUM: begin
          if (tail_valid && !tail_last) begin
            acc <= sum[ACC_W-1:0];
            ovf <= ovf | carry;
          end
          if (fire && op_last) begin
            state <= ST_DRAIN;
          end
        end
        // No new pairs arrive here, so clearing cnt cannot lose a term.
        ST_DRAIN: begin
          if (tail_valid) begin
            if (tail_last) begin
              out_sum   <= sum[ACC_W-1:0];
              out_count <= cnt;
              out_ovf   <= ovf | carry;
              out_valid <= 1'b1;
              acc       <= '0;
              cnt       <= '0;
              ovf       <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              acc <= sum[ACC_W-1:0];
              ovf <= ovf | carry;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

endmodule
